// File: rtl/mem_stage_ctrl_pkg.sv
// rtl/mem_stage_ctrl_pkg.sv - shared control-word bit indices and FSM encoding for the MEM stage
package mem_stage_ctrl_pkg;

   localparam int CTRL_W       = 9;
   localparam int WB_EN_BIT    = 8;
   localparam int MEM_R_EN_BIT = 7;
   localparam int MEM_W_EN_BIT = 6;
   localparam int EXE_CMD_HI   = 5;
   localparam int EXE_CMD_LO   = 2;
   localparam int B_BIT        = 1;
   localparam int S_BIT        = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - SRAM access-cycle counter with terminal count at WAIT_CYCLES-1
module mem_wait_counter #(
   parameter int WAIT_CYCLES = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic enable,
   output logic tc
);

   logic [3:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= 4'd0;
      end else if (load) begin
         cnt <= 4'd0;
      end else if (enable) begin
         cnt <= cnt + 4'd1;
      end
   end

   assign tc = (cnt == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM pipeline stage: multi-cycle SRAM load/store sequencing and WB bundle
import mem_stage_ctrl_pkg::*;

module mem_stage_ctrl #(
   parameter int          WAIT_CYCLES = 5,
   parameter int unsigned ADDR_BASE   = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic [8:0]  ctrl_in,
   input  logic [31:0] alu_res,
   input  logic [31:0] st_val,
   input  logic [3:0]  dest,
   output logic        freeze,
   output logic [31:0] sram_addr,
   output logic        sram_re,
   output logic        sram_we,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   output logic        wb_valid,
   output logic        wb_en,
   output logic [31:0] wb_value,
   output logic [3:0]  wb_dest
);

   mem_state_e  state, next_state;
   logic        is_mem, accept_mem, accept_alu;
   logic        cnt_load, cnt_en, cnt_tc;
   logic        rd_q, wr_q;
   logic [3:0]  dest_q;
   logic [31:0] addr_q, wdata_q, byte_off;
   logic        unused_bits;

   // The subtraction wraps naturally for addresses below ADDR_BASE.
   assign byte_off    = alu_res - ADDR_BASE[31:0];
   assign unused_bits = ^{ctrl_in[EXE_CMD_HI:S_BIT], byte_off[1:0]};

   assign is_mem     = ctrl_in[MEM_R_EN_BIT] | ctrl_in[MEM_W_EN_BIT];
   assign accept_mem = (state == ST_IDLE) && valid_in && is_mem;
   assign accept_alu = (state == ST_IDLE) && valid_in && !is_mem;

   mem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (cnt_load),
      .enable (cnt_en),
      .tc     (cnt_tc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      freeze     = 1'b0;
      sram_re    = 1'b0;
      sram_we    = 1'b0;
      cnt_load   = 1'b0;
      cnt_en     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept_mem) begin
               freeze     = 1'b1;
               cnt_load   = 1'b1;
               next_state = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            freeze  = 1'b1;
            cnt_en  = 1'b1;
            sram_re = rd_q;
            // A read+write request is a load; the write strobe is suppressed.
            sram_we = wr_q & ~rd_q;
            if (cnt_tc) next_state = ST_DONE;
         end
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_valid <= 1'b0;
         wb_en    <= 1'b0;
         wb_value <= 32'd0;
         wb_dest  <= 4'd0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         dest_q   <= 4'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
      end else begin
         wb_valid <= 1'b0;
         wb_en    <= 1'b0;
         if (accept_alu) begin
            wb_valid <= 1'b1;
            wb_en    <= ctrl_in[WB_EN_BIT];
            wb_value <= alu_res;
            wb_dest  <= dest;
         end
         if (accept_mem) begin
            rd_q    <= ctrl_in[MEM_R_EN_BIT];
            wr_q    <= ctrl_in[MEM_W_EN_BIT];
            dest_q  <= dest;
            addr_q  <= {2'b00, byte_off[31:2]};
            wdata_q <= st_val;
         end
         // Final access cycle: read data is valid now, WB bundle appears in DONE.
         if (state == ST_ACCESS && cnt_tc) begin
            wb_valid <= 1'b1;
            wb_en    <= rd_q;
            wb_dest  <= dest_q;
            if (rd_q) wb_value <= sram_rdata;
         end
      end
   end

   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

   logic        clk;
   logic        rst_n;
   logic        valid_in;
   logic [8:0]  ctrl_in;
   logic [31:0] alu_res;
   logic [31:0] st_val;
   logic [3:0]  dest;
   logic        freeze;
   logic [31:0] sram_addr;
   logic        sram_re;
   logic        sram_we;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        wb_valid;
   logic        wb_en;
   logic [31:0] wb_value;
   logic [3:0]  wb_dest;

   int checks = 0;
   int errors = 0;

   int fz_n, re_n, we_n, both_n, lat, wbv_n;
   logic [31:0] addr_seen, wd_seen;

   mem_stage_ctrl #(.WAIT_CYCLES(5), .ADDR_BASE(1024)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_in   (valid_in),
      .ctrl_in    (ctrl_in),
      .alu_res    (alu_res),
      .st_val     (st_val),
      .dest       (dest),
      .freeze     (freeze),
      .sram_addr  (sram_addr),
      .sram_re    (sram_re),
      .sram_we    (sram_we),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .wb_valid   (wb_valid),
      .wb_en      (wb_en),
      .wb_value   (wb_value),
      .wb_dest    (wb_dest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic present(input logic [8:0] c, input logic [31:0] a, input logic [31:0] sv,
                          input logic [3:0] d);
      valid_in = 1'b1;
      ctrl_in  = c;
      alu_res  = a;
      st_val   = sv;
      dest     = d;
      #1;
   endtask

   // Runs a memory op from its IDLE request cycle until wb_valid; leaves the bench in DONE.
   task automatic mem_op(input logic [8:0] c, input logic [31:0] a, input logic [31:0] sv,
                         input logic [3:0] d);
      fz_n = 0; re_n = 0; we_n = 0; both_n = 0; lat = -1;
      addr_seen = 32'hx; wd_seen = 32'hx;
      present(c, a, sv, d);
      for (int i = 0; i < 20; i++) begin
         if (wb_valid) begin
            lat = i;
            break;
         end
         fz_n += int'(freeze);
         re_n += int'(sram_re);
         we_n += int'(sram_we);
         if (sram_re && sram_we) both_n++;
         if (sram_re || sram_we) begin
            addr_seen = sram_addr;
            wd_seen   = sram_wdata;
         end
         step();
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      valid_in   = 1'b0;
      ctrl_in    = 9'd0;
      alu_res    = 32'd0;
      st_val     = 32'd0;
      dest       = 4'd0;
      sram_rdata = 32'd0;
      step();
      step();
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_wb_en", 32'(wb_en), 32'd0);
      check("rst_freeze", 32'(freeze), 32'd0);
      check("rst_strobes", {30'd0, sram_re, sram_we}, 32'd0);
      check("rst_wb_value", wb_value, 32'd0);
      check("rst_wb_dest", 32'(wb_dest), 32'd0);
      check("rst_sram_addr", sram_addr, 32'd0);
      check("rst_sram_wdata", sram_wdata, 32'd0);
      rst_n = 1'b1;
      step();

      // ADD: single-cycle write-back, no stall
      present(9'b1_0_0_0100_0_0, 32'd7, 32'd0, 4'd3);
      check("add_freeze_req", 32'(freeze), 32'd0);
      step();
      valid_in = 1'b0;
      #1;
      check("add_wb_valid", 32'(wb_valid), 32'd1);
      check("add_wb_en", 32'(wb_en), 32'd1);
      check("add_wb_value", wb_value, 32'd7);
      check("add_wb_dest", 32'(wb_dest), 32'd3);
      check("add_freeze", 32'(freeze), 32'd0);
      step();
      check("add_wb_drop", 32'(wb_valid), 32'd0);

      // Load
      sram_rdata = 32'hDEADBEEF;
      mem_op(9'b1_1_0_0010_0_1, 32'd1028, 32'd0, 4'd6);
      check("ld_latency", 32'(lat), 32'd6);
      check("ld_freeze_cycles", 32'(fz_n), 32'd6);
      check("ld_re_cycles", 32'(re_n), 32'd5);
      check("ld_we_cycles", 32'(we_n), 32'd0);
      check("ld_addr", addr_seen, 32'd1);
      check("ld_wb_en", 32'(wb_en), 32'd1);
      check("ld_wb_value", wb_value, 32'hDEADBEEF);
      check("ld_wb_dest", 32'(wb_dest), 32'd6);
      check("ld_done_freeze", 32'(freeze), 32'd0);
      valid_in = 1'b0;
      step();
      check("ld_wb_drop", 32'(wb_valid), 32'd0);

      // Store
      mem_op(9'b0_0_1_0010_0_0, 32'd1032, 32'h55, 4'd0);
      check("st_latency", 32'(lat), 32'd6);
      check("st_we_cycles", 32'(we_n), 32'd5);
      check("st_re_cycles", 32'(re_n), 32'd0);
      check("st_addr", addr_seen, 32'd2);
      check("st_wdata", wd_seen, 32'h55);
      check("st_wb_en", 32'(wb_en), 32'd0);
      valid_in = 1'b0;
      step();

      // Read+write both set behaves as a load
      sram_rdata = 32'h12345678;
      mem_op(9'b1_1_1_0000_0_0, 32'd1036, 32'hAA, 4'd9);
      check("rw_we_cycles", 32'(we_n), 32'd0);
      check("rw_re_cycles", 32'(re_n), 32'd5);
      check("rw_both", 32'(both_n), 32'd0);
      check("rw_addr", addr_seen, 32'd3);
      check("rw_wb_en", 32'(wb_en), 32'd1);
      check("rw_wb_value", wb_value, 32'h12345678);
      valid_in = 1'b0;
      step();

      // Address below ADDR_BASE wraps: (0 - 1024) >> 2
      mem_op(9'b1_1_0_0000_0_0, 32'd0, 32'd0, 4'd1);
      check("wrap_addr", addr_seen, 32'h3FFFFF00);
      valid_in = 1'b0;
      step();

      // Branch
      present(9'b0_0_0_0000_1_0, 32'd44, 32'd0, 4'd2);
      step();
      valid_in = 1'b0;
      #1;
      check("br_wb_valid", 32'(wb_valid), 32'd1);
      check("br_wb_en", 32'(wb_en), 32'd0);
      step();

      // Back-to-back: load, then ADD presented once the stage unfreezes
      sram_rdata = 32'hCAFE0001;
      mem_op(9'b1_1_0_0010_0_1, 32'd1040, 32'd0, 4'd4);
      check("b2b_ld_latency", 32'(lat), 32'd6);
      check("b2b_ld_value", wb_value, 32'hCAFE0001);
      present(9'b1_0_0_0100_0_0, 32'h99, 32'd0, 4'd5);
      step();
      check("b2b_gap_wb_valid", 32'(wb_valid), 32'd0);
      check("b2b_idle_freeze", 32'(freeze), 32'd0);
      step();
      valid_in = 1'b0;
      #1;
      check("b2b_add_wb_valid", 32'(wb_valid), 32'd1);
      check("b2b_add_value", wb_value, 32'h99);
      check("b2b_add_dest", 32'(wb_dest), 32'd5);
      step();
      check("b2b_add_drop", 32'(wb_valid), 32'd0);

      // Reset on the 3rd ACCESS cycle
      present(9'b1_1_0_0010_0_1, 32'd1028, 32'd0, 4'd7);
      step();
      step();
      step();
      check("rma_re_before", 32'(sram_re), 32'd1);
      rst_n    = 1'b0;
      valid_in = 1'b0;
      step();
      check("rma_strobes", {30'd0, sram_re, sram_we}, 32'd0);
      check("rma_freeze", 32'(freeze), 32'd0);
      check("rma_wb_valid", 32'(wb_valid), 32'd0);
      rst_n = 1'b1;
      wbv_n = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         wbv_n += int'(wb_valid);
      end
      check("rma_no_wb", 32'(wbv_n), 32'd0);
      present(9'b1_0_0_0100_0_0, 32'd21, 32'd0, 4'd8);
      step();
      valid_in = 1'b0;
      #1;
      check("rma_idle_add", 32'(wb_valid), 32'd1);
      check("rma_idle_value", wb_value, 32'd21);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
